// File: rtl/gray_counter_bank_if.sv
// Control, load, read and status bundle of the Gray counter bank.
interface gray_counter_bank_if #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4,
  parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [CHANNELS-1:0]       inc_en;
  logic [CHANNELS-1:0]       dec_en;
  logic                      wr_en;
  logic [SELW-1:0]           wr_sel;
  logic                      wr_is_gray;
  logic [WIDTH-1:0]          wr_value;
  logic [SELW-1:0]           rd_sel;
  logic [WIDTH-1:0]          rd_gray;
  logic [WIDTH-1:0]          rd_bin;
  logic [CHANNELS*WIDTH-1:0] all_gray;
  logic [CHANNELS-1:0]       at_max;
  logic [CHANNELS-1:0]       at_min;
  logic [CHANNELS-1:0]       wrap_pulse;
  logic                      err;
  logic                      err_clr;

  modport master (
    output inc_en, dec_en, wr_en, wr_sel, wr_is_gray, wr_value, rd_sel, err_clr,
    input  rd_gray, rd_bin, all_gray, at_max, at_min, wrap_pulse, err
  );

  modport slave (
    input  inc_en, dec_en, wr_en, wr_sel, wr_is_gray, wr_value, rd_sel, err_clr,
    output rd_gray, rd_bin, all_gray, at_max, at_min, wrap_pulse, err
  );
endinterface

// File: rtl/gray_counter_bank.sv
// Bank of independent up/down Gray counters with load, wrap/saturate, flags and a registered read port.
// Optional step checker enabled by defining GRAY_BANK_STEP_CHECK_EN.
module gray_counter_bank #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 0,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input logic CLK,
  input logic nRST,
  gray_counter_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_BIN  = '1;
  localparam logic [WIDTH-1:0] GRAY_MAX = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]            wrap_q, wrap_d;
  logic [CHANNELS-1:0]            wr_hit;
  logic [WIDTH-1:0]               rd_gray_q, rd_gray_d;
  logic [WIDTH-1:0]               rd_bin_q, rd_bin_d;
  logic [WIDTH-1:0]               cur_bin;
  logic [WIDTH-1:0]               load_val;

  always_comb begin
    cnt_d     = cnt_q;
    wrap_d    = '0;
    wr_hit    = '0;
    cur_bin   = '0;
    rd_gray_d = '0;
    load_val  = bus.wr_is_gray ? bus.wr_value : b2g(bus.wr_value);
    for (int i = 0; i < CHANNELS; i++) begin
      cur_bin   = g2b(cnt_q[i]);
      // Out-of-range wr_sel matches no channel, so the write is dropped.
      wr_hit[i] = bus.wr_en && (bus.wr_sel == SELW'(i));
      if (wr_hit[i]) begin
        cnt_d[i] = load_val;
      end else if (bus.inc_en[i] != bus.dec_en[i]) begin
        if (bus.inc_en[i]) begin
          if (cur_bin != MAX_BIN) begin
            cnt_d[i] = b2g(cur_bin + WIDTH'(1));
          end else if (SATURATE == 0) begin
            cnt_d[i]  = '0;
            wrap_d[i] = 1'b1;
          end
        end else begin
          if (cur_bin != '0) begin
            cnt_d[i] = b2g(cur_bin - WIDTH'(1));
          end else if (SATURATE == 0) begin
            cnt_d[i]  = GRAY_MAX;
            wrap_d[i] = 1'b1;
          end
        end
      end
      // Read port samples the pre-update state; out-of-range selects read 0.
      if (bus.rd_sel == SELW'(i)) rd_gray_d = cnt_q[i];
    end
    rd_bin_d = g2b(rd_gray_d);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q     <= '0;
      wrap_q    <= '0;
      rd_gray_q <= '0;
      rd_bin_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wrap_q    <= wrap_d;
      rd_gray_q <= rd_gray_d;
      rd_bin_q  <= rd_bin_d;
    end
  end

  always_comb begin
    bus.at_max = '0;
    bus.at_min = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      bus.at_max[i] = (cnt_q[i] == GRAY_MAX);
      bus.at_min[i] = (cnt_q[i] == '0);
    end
  end

  assign bus.all_gray   = cnt_q;
  assign bus.wrap_pulse = wrap_q;
  assign bus.rd_gray    = rd_gray_q;
  assign bus.rd_bin     = rd_bin_q;

`ifdef GRAY_BANK_STEP_CHECK_EN
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;
  logic [CHANNELS-1:0]            load_q, load_d;
  logic                           err_q, err_d;
  logic [WIDTH-1:0]               diff;

  // A transition caused by a load is legal to jump any distance.
  always_comb begin
    shadow_d = cnt_q;
    load_d   = wr_hit;
    err_d    = err_q & ~bus.err_clr;
    diff     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      diff = shadow_q[i] ^ cnt_q[i];
      if (!load_q[i] && ((diff & (diff - WIDTH'(1))) != '0)) err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      shadow_q <= '0;
      load_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      load_q   <= load_d;
      err_q    <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter_bank.sv
// Directed bench: a wrapping 4-channel bank and a saturating 6-channel bank, both WIDTH=4.
module tb_gray_counter_bank;
  logic CLK = 1'b0;
  logic nRST;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  localparam logic [3:0] GSEQ [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                        4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  gray_counter_bank_if #(.WIDTH(4), .CHANNELS(4)) ia ();
  gray_counter_bank_if #(.WIDTH(4), .CHANNELS(6)) ib ();

  gray_counter_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(0)) dut_a (.CLK(CLK), .nRST(nRST), .bus(ia));
  gray_counter_bank #(.WIDTH(4), .CHANNELS(6), .SATURATE(1)) dut_b (.CLK(CLK), .nRST(nRST), .bus(ib));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] prev, cur;
    int pulses;
    nRST = 1'b0;
    ia.inc_en = '0; ia.dec_en = '0; ia.wr_en = 1'b0; ia.wr_sel = '0; ia.wr_is_gray = 1'b0;
    ia.wr_value = '0; ia.rd_sel = '0; ia.err_clr = 1'b0;
    ib.inc_en = '0; ib.dec_en = '0; ib.wr_en = 1'b0; ib.wr_sel = '0; ib.wr_is_gray = 1'b0;
    ib.wr_value = '0; ib.rd_sel = '0; ib.err_clr = 1'b0;

    // Reset and idle.
    tick(); tick();
    nRST = 1'b1;
    repeat (3) tick();
    chk("rst_all_gray", ia.all_gray, 32'h0);
    chk("rst_at_min", ia.at_min, 32'hF);
    chk("rst_at_max", ia.at_max, 32'h0);
    chk("rst_rd_gray", ia.rd_gray, 32'h0);
    chk("rst_rd_bin", ia.rd_bin, 32'h0);
    chk("rst_err", ia.err, 32'h0);
    chk("rst_wrap", ia.wrap_pulse, 32'h0);
    chk("rst_b_at_min", ib.at_min, 32'h3F);

    // Wrapping increment through the full Gray sequence on ch0.
    ia.inc_en = 4'b0001;
    prev = 4'h0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      cur = ia.all_gray[3:0];
      chk("inc_seq", cur, GSEQ[k % 16]);
      chk("one_bit", $countones(cur ^ prev), 1);
      chk("wrap_pulse0", ia.wrap_pulse[0], (k == 16) ? 1 : 0);
      if (k == 15) chk("at_max0", ia.at_max[0], 1);
      prev = cur;
    end
    ia.inc_en = '0;
    tick();
    chk("wrap_pulse_drop", ia.wrap_pulse, 32'h0);
    chk("ch0_zero", ia.all_gray[3:0], 32'h0);

    // Saturating bank ch1: up then down past the ends.
    ib.inc_en = 6'b000010;
    pulses = 0;
    repeat (20) begin tick(); pulses += int'(ib.wrap_pulse[1]); end
    chk("sat_max", ib.all_gray[7:4], 32'h8);
    chk("sat_at_max", ib.at_max[1], 1);
    chk("sat_no_pulse_up", pulses, 0);
    ib.inc_en = '0;
    ib.dec_en = 6'b000010;
    pulses = 0;
    repeat (20) begin tick(); pulses += int'(ib.wrap_pulse[1]); end
    chk("sat_min", ib.all_gray[7:4], 32'h0);
    chk("sat_at_min", ib.at_min[1], 1);
    chk("sat_no_pulse_dn", pulses, 0);
    ib.dec_en = '0;

    // Binary load beats concurrent increment; read port lags by one edge.
    ia.wr_en = 1'b1; ia.wr_sel = 2'd2; ia.wr_is_gray = 1'b0; ia.wr_value = 4'd10; ia.inc_en = 4'b0100;
    tick();
    chk("load_bin", ia.all_gray[11:8], 32'hF);
    ia.wr_en = 1'b0; ia.inc_en = '0; ia.rd_sel = 2'd2;
    tick();
    chk("rd_bin_ch2", ia.rd_bin, 32'd10);
    chk("rd_gray_ch2", ia.rd_gray, 32'hF);
    ia.wr_en = 1'b1; ia.wr_is_gray = 1'b1; ia.wr_value = 4'b0101;
    tick();
    chk("load_gray", ia.all_gray[11:8], 32'h5);
    chk("rd_gray_stale", ia.rd_gray, 32'hF);
    ia.wr_en = 1'b0;
    tick();
    chk("rd_gray_new", ia.rd_gray, 32'h5);
    chk("rd_bin_new", ia.rd_bin, 32'd6);

    // inc and dec together hold.
    ia.inc_en = 4'b1000; ia.dec_en = 4'b1000;
    repeat (5) begin
      tick();
      chk("inc_dec_hold", ia.all_gray, 32'h0500);
    end
    ia.inc_en = '0; ia.dec_en = '0;

    // Out-of-range write and read selects on the 6-channel bank.
    ib.wr_en = 1'b1; ib.wr_sel = 3'd7; ib.wr_is_gray = 1'b1; ib.wr_value = 4'hF;
    tick();
    chk("wr_sel7_drop", ib.all_gray, 32'h0);
    ib.wr_sel = 3'd6;
    tick();
    chk("wr_sel6_drop", ib.all_gray, 32'h0);
    ib.wr_sel = 3'd1; ib.wr_is_gray = 1'b0; ib.wr_value = 4'd3; ib.rd_sel = 3'd1;
    tick();
    ib.wr_en = 1'b0;
    tick();
    chk("b_rd_gray_ch1", ib.rd_gray, 32'h2);
    chk("b_rd_bin_ch1", ib.rd_bin, 32'h3);
    ib.rd_sel = 3'd7;
    tick();
    chk("rd_sel7_gray", ib.rd_gray, 32'h0);
    chk("rd_sel7_bin", ib.rd_bin, 32'h0);
    ib.rd_sel = 3'd6;
    tick();
    chk("rd_sel6_gray", ib.rd_gray, 32'h0);

    // Step checker.
`ifdef GRAY_BANK_STEP_CHECK_EN
    force dut_a.cnt_q = 16'h0503;
    #1;
    release dut_a.cnt_q;
    tick();
    chk("forced_ch0", ia.all_gray[3:0], 32'h3);
    chk("err_set", ia.err, 32'h1);
    tick();
    chk("err_held", ia.err, 32'h1);
    ia.err_clr = 1'b1;
    tick();
    chk("err_cleared", ia.err, 32'h0);
    ia.err_clr = 1'b0;
`else
    ia.err_clr = 1'b1;
    tick();
    chk("err_tied", ia.err, 32'h0);
    ia.err_clr = 1'b0;
`endif

    // Reset landing during an active increment.
    ia.inc_en = 4'b0001;
    nRST = 1'b0;
    tick();
    chk("midrst_gray", ia.all_gray, 32'h0);
    chk("midrst_at_min", ia.at_min, 32'hF);
    chk("midrst_rd", ia.rd_gray, 32'h0);
    chk("midrst_err", ia.err, 32'h0);
    chk("midrst_b_gray", ib.all_gray, 32'h0);
    ia.inc_en = '0;
    nRST = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
